mpsk_phase_gen: RTL and testbench
=================================

// Module: mpsk_phase_gen
// PURPOSE
//   Parametrised M-PSK phase generator for the BPSK/QPSK/8PSK modulator path. Accumulates carrier
//   phase with a programmable frequency word, adds a per-symbol phase offset, emits a phase index
//   into the sine table. Symbols arrive on a valid/ready handshake into a 1-deep buffer, replacing
//   the toggle-style bit request; symbol length (samples per symbol) and modulation order are runtime.
// PARAMETERS
//   PHASE_W  8  phase output width; sine table depth = 2**PHASE_W; must be >= 3
//   FRAC_W   8  fractional accumulator bits; ACC_W = PHASE_W+FRAC_W
//   SPS_W    8  width of samples-per-symbol input
//   GRAY     1  1: symbol bits Gray-decoded before mapping; 0: straight binary
// PORTS
//   clock        in   1        sample clock, all state on rising edge
//   reset_n      in   1        asynchronous active-low reset
//   enable       in   1        1: advance one sample this cycle; 0: hold sample state
//   freq_word    in   ACC_W    accumulator increment per enabled cycle
//   sps          in   SPS_W    samples per symbol, sampled at symbol boundary; 0 treated as 1
//   mode         in   2        0 BPSK(k=1), 1 QPSK(k=2), 2 8PSK(k=3), 3 reserved = BPSK; sampled at boundary
//   sym_valid    in   1        symbol offered
//   sym_data     in   3        symbol; only bits [k-1:0] used
//   sym_ready    out  1        = ~buf_full (registered state); symbol accepted when valid & ready
//   phase        out  PHASE_W  sine table index
//   phase_valid  out  1        phase holds a new sample
//   sym_start    out  1        1-cycle pulse with first sample of a newly loaded symbol
//   underrun     out  1        1-cycle pulse with first sample of a boundary that found buffer empty
// BEHAVIOUR
//   - Reset (async, reset_n=0): acc=0, cnt=0, buf_full=0, cur_off=0, phase=0, phase_valid=0,
//     sym_start=0, underrun=0; sym_ready=1 while in reset and after. Buffered symbol discarded.
//   - Handshake: accept when sym_valid & sym_ready; buffer written at that edge; ready drops next
//     cycle. No bypass: symbol accepted in cycle T is usable only at boundaries from T+1 on.
//     Acceptance is independent of enable.
//   - Boundary = enable & (cnt==0). At boundary: cnt <= max(sps,1)-1, mode_l <= mode;
//     if buf_full: cur_off <= map(buffer, mode), buf_full <= 0, sym_start next cycle;
//     else: cur_off <= 0, underrun next cycle (carrier continues unmodulated).
//     Boundary + acceptance same cycle with buffer empty: underrun; symbol kept for next boundary.
//   - Non-boundary enabled cycle: cnt <= cnt-1. First enabled cycle after reset is a boundary.
//   - map: b = sym_data[k-1:0]; if GRAY, b = gray-to-binary(b); off = b << (PHASE_W-k).
//   - Enabled cycle: phase <= acc[ACC_W-1 -: PHASE_W] + off (mod 2**PHASE_W), where off is the
//     new offset on a boundary, else cur_off; acc <= acc + freq_word (mod 2**ACC_W).
//     Latency 1: sample from acc value of cycle T appears on phase in T+1 with phase_valid=1.
//   - enable=0: acc, cnt, cur_off, mode_l hold; phase holds; phase_valid, sym_start, underrun = 0.
//   - Wrap: accumulator and phase sum wrap modulo width, no saturation.
//   - sps/mode/freq_word changes mid-symbol: sps, mode take effect at next boundary; freq_word immediately.
// TESTING
//   1 BPSK: PHASE_W=8 FRAC_W=0 freq=1 sps=4, symbols 0,1 preloaded -> phase 0,1,2,3,132,133,134,135;
//     sym_start on samples 0 and 4.
//   2 QPSK GRAY=1 freq=0: symbol 2'b11 -> phase 128 (gray 11=bin 2); 2'b10 -> phase 192.
//   3 Underrun: sym_valid=0, sps=2, freq=1 -> phase 0,1,2,3..., underrun pulses on samples 0,2,4; no sym_start.
//   4 Backpressure: sym_valid=1 always, counting data, sps=3 -> exactly one accept per 3 samples,
//     offsets follow data order, no drop/duplicate; sym_ready low between boundaries.
//   5 Wrap: FRAC_W=0 freq=0x40, 8PSK symbol 6 (bin, GRAY=0, off=192) -> phase 192,0,64,128,192.
//   6 enable toggled 1,0,0,1 -> phase_valid 0 for 2 cycles, next sample continues without skip;
//     reset_n pulsed mid-symbol with buffer full -> all outputs 0 immediately, sym_ready=1,
//     next symbol sent plays from phase 0 with sym_start, old buffered symbol never appears.

Source files
------------

// File: rtl/mpsk_phase_gen_if.sv
// Symbol handshake between the symbol source and the M-PSK phase generator.
// The source raises sym_valid with sym_data; the generator raises sym_ready while its buffer is empty.
interface mpsk_phase_gen_if;
    logic       sym_valid;
    logic [2:0] sym_data;
    logic       sym_ready;

    modport master (output sym_valid, output sym_data, input sym_ready);
    modport slave  (input sym_valid, input sym_data, output sym_ready);
endinterface

// File: rtl/mpsk_phase_gen.sv
// M-PSK phase generator: a carrier phase accumulator plus a per-symbol offset gives a sine-table index.
// Symbols arrive through a 1-deep buffer and are consumed at symbol boundaries.
module mpsk_phase_gen #(
    parameter int PHASE_W = 8,
    parameter int FRAC_W  = 8,
    parameter int SPS_W   = 8,
    parameter int GRAY    = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [PHASE_W+FRAC_W-1:0]  freq_word,
    input  logic [SPS_W-1:0]           sps,
    input  logic [1:0]                 mode,
    mpsk_phase_gen_if.slave            sym,
    output logic [PHASE_W-1:0]         phase,
    output logic                       phase_valid,
    output logic                       sym_start,
    output logic                       underrun
);
    localparam int ACC_W = PHASE_W + FRAC_W;

    logic [ACC_W-1:0]   acc_reg;
    logic [SPS_W-1:0]   cnt_reg;
    logic               buf_full_reg;
    logic [2:0]         buf_data_reg;
    logic [PHASE_W-1:0] cur_off_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic               phase_valid_reg;
    logic               sym_start_reg;
    logic               underrun_reg;

    logic               boundary;
    logic               accept;
    logic [2:0]         sym_mask;
    logic [2:0]         sym_bits;
    logic [2:0]         sym_bin;
    logic [PHASE_W-1:0] map_off;
    logic [PHASE_W-1:0] boundary_off;
    logic [PHASE_W-1:0] off_sel;
    logic [PHASE_W-1:0] phase_next;
    logic [SPS_W-1:0]   cnt_load;

    assign boundary  = enable && (cnt_reg == '0);
    assign accept    = sym.sym_valid && !buf_full_reg;
    assign sym.sym_ready = !buf_full_reg;

    // Reserved mode 3 behaves as BPSK.
    always_comb begin
        sym_mask = 3'b001;
        case (mode)
            2'd1:    sym_mask = 3'b011;
            2'd2:    sym_mask = 3'b111;
            default: sym_mask = 3'b001;
        endcase
    end

    assign sym_bits = buf_data_reg & sym_mask;

    // Bits above k are zero after masking, so a 3-bit prefix XOR decodes every order.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_decode
            if (GRAY != 0) begin : g_gray
                assign sym_bin[gi] = ^sym_bits[2:gi];
            end else begin : g_bin
                assign sym_bin[gi] = sym_bits[gi];
            end
        end
    endgenerate

    always_comb begin
        map_off = PHASE_W'(sym_bin[0]) << (PHASE_W - 1);
        case (mode)
            2'd1:    map_off = PHASE_W'(sym_bin[1:0]) << (PHASE_W - 2);
            2'd2:    map_off = PHASE_W'(sym_bin) << (PHASE_W - 3);
            default: map_off = PHASE_W'(sym_bin[0]) << (PHASE_W - 1);
        endcase
    end

    // An empty buffer at a boundary leaves the carrier unmodulated for that symbol.
    assign boundary_off = buf_full_reg ? map_off : '0;
    assign off_sel      = boundary ? boundary_off : cur_off_reg;
    assign phase_next   = acc_reg[ACC_W-1 -: PHASE_W] + off_sel;
    assign cnt_load     = (sps == '0) ? '0 : sps - SPS_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg         <= '0;
            cnt_reg         <= '0;
            buf_full_reg    <= 1'b0;
            buf_data_reg    <= '0;
            cur_off_reg     <= '0;
            phase_reg       <= '0;
            phase_valid_reg <= 1'b0;
            sym_start_reg   <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            // No bypass: a symbol written here is only seen by later boundaries.
            if (accept) begin
                buf_full_reg <= 1'b1;
                buf_data_reg <= sym.sym_data;
            end else if (boundary && buf_full_reg) begin
                buf_full_reg <= 1'b0;
            end

            if (enable) begin
                acc_reg         <= acc_reg + freq_word;
                phase_reg       <= phase_next;
                phase_valid_reg <= 1'b1;
                sym_start_reg   <= boundary && buf_full_reg;
                underrun_reg    <= boundary && !buf_full_reg;
                if (boundary) begin
                    cnt_reg     <= cnt_load;
                    cur_off_reg <= boundary_off;
                end else begin
                    cnt_reg     <= cnt_reg - SPS_W'(1);
                end
            end else begin
                phase_valid_reg <= 1'b0;
                sym_start_reg   <= 1'b0;
                underrun_reg    <= 1'b0;
            end
        end
    end

    assign phase       = phase_reg;
    assign phase_valid = phase_valid_reg;
    assign sym_start   = sym_start_reg;
    assign underrun    = underrun_reg;
endmodule

// File: tb/tb_mpsk_phase_gen.sv
// Bench for mpsk_phase_gen (PHASE_W=8, FRAC_W=0, GRAY=1): expected samples are queued as stimulus
// is driven and popped by a negedge monitor whenever phase_valid is high.
module tb_mpsk_phase_gen;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] freq_word;
    logic [7:0] sps;
    logic [1:0] mode;
    logic [7:0] phase;
    logic       phase_valid;
    logic       sym_start;
    logic       underrun;

    mpsk_phase_gen_if sym_bus();

    mpsk_phase_gen #(.PHASE_W(8), .FRAC_W(0), .SPS_W(8), .GRAY(1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .freq_word   (freq_word),
        .sps         (sps),
        .mode        (mode),
        .sym         (sym_bus),
        .phase       (phase),
        .phase_valid (phase_valid),
        .sym_start   (sym_start),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] phase;
        logic       ss;
        logic       ur;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] sym;
        logic [7:0] phase;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[12];
    logic [7:0] qpsk_exp[4];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] p, input logic ss, input logic ur);
        exp_t e;
        e.phase = p;
        e.ss    = ss;
        e.ur    = ur;
        exp_q.push_back(e);
    endtask

    task automatic send_sym(input logic [2:0] d);
        int n;
        n = 0;
        sym_bus.sym_valid = 1'b1;
        sym_bus.sym_data  = d;
        while (!sym_bus.sym_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 32'(sym_bus.sym_ready), 32'd1);
        tick();
        sym_bus.sym_valid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        tick();
        tick();
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic apply_reset();
        enable            = 1'b0;
        sym_bus.sym_valid = 1'b0;
        reset_n           = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1 && phase_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_sample: got phase %0d, required no sample", phase);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] sample phase=%0d sym_start=%0b underrun=%0b", phase, sym_start, underrun);
                chk("phase", 32'(phase), 32'(mon_e.phase));
                chk("sym_start", 32'(sym_start), 32'(mon_e.ss));
                chk("underrun", 32'(underrun), 32'(mon_e.ur));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_cnt;
        logic [7:0] d;
        logic was_ready;

        vecs[0]  = '{2'd0, 3'b000, 8'd0};
        vecs[1]  = '{2'd0, 3'b001, 8'd128};
        vecs[2]  = '{2'd1, 3'b000, 8'd0};
        vecs[3]  = '{2'd1, 3'b001, 8'd64};
        vecs[4]  = '{2'd1, 3'b011, 8'd128};
        vecs[5]  = '{2'd1, 3'b010, 8'd192};
        vecs[6]  = '{2'd2, 3'b111, 8'd160};
        vecs[7]  = '{2'd2, 3'b100, 8'd224};
        vecs[8]  = '{2'd2, 3'b010, 8'd96};
        vecs[9]  = '{2'd3, 3'b011, 8'd128};
        vecs[10] = '{2'd1, 3'b111, 8'd128};
        vecs[11] = '{2'd2, 3'b001, 8'd32};
        qpsk_exp[0] = 8'd0;
        qpsk_exp[1] = 8'd64;
        qpsk_exp[2] = 8'd192;
        qpsk_exp[3] = 8'd128;

        reset_n = 1'b0; enable = 1'b0; freq_word = '0; sps = '0; mode = '0;
        sym_bus.sym_valid = 1'b0; sym_bus.sym_data = '0;
        #12;
        chk("reset_phase", 32'(phase), 32'd0);
        chk("reset_phase_valid", 32'(phase_valid), 32'd0);
        chk("reset_sym_start", 32'(sym_start), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        chk("reset_sym_ready", 32'(sym_bus.sym_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        tick();

        // BPSK, sps=4, two symbols: second accepted while the first plays.
        freq_word = 8'd1; sps = 8'd4; mode = 2'd0;
        send_sym(3'd0);
        for (int i = 0; i < 8; i++)
            push(8'(i + ((i >= 4) ? 128 : 0)), (i == 0 || i == 4), 1'b0);
        enable = 1'b1;
        fork
            begin
                repeat (8) tick();
                enable = 1'b0;
            end
            send_sym(3'd1);
        join
        drain_check("bpsk_drain");

        // Mapping table, one sample per symbol, sps=0 behaves as 1.
        apply_reset();
        freq_word = 8'd0; sps = 8'd0;
        for (int i = 0; i < 12; i++) begin
            mode = vecs[i].mode;
            send_sym(vecs[i].sym);
            push(vecs[i].phase, 1'b1, 1'b0);
            enable = 1'b1;
            tick();
            enable = 1'b0;
            tick();
        end
        drain_check("table_drain");

        // Underrun: no symbols offered.
        apply_reset();
        freq_word = 8'd1; sps = 8'd2; mode = 2'd0;
        for (int i = 0; i < 6; i++) push(8'(i), 1'b0, ((i % 2) == 0));
        enable = 1'b1;
        repeat (6) tick();
        enable = 1'b0;
        drain_check("underrun_drain");

        // Backpressure: valid held high with counting data, QPSK, sps=3.
        apply_reset();
        freq_word = 8'd0; sps = 8'd3; mode = 2'd1;
        d = 8'd0;
        sym_bus.sym_valid = 1'b1;
        sym_bus.sym_data  = d[2:0];
        tick();
        d = 8'd1;
        sym_bus.sym_data = d[2:0];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) push(qpsk_exp[i], (j == 0), 1'b0);
        acc_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            enable = 1'b1;
            was_ready = sym_bus.sym_ready;
            tick();
            if (was_ready) begin
                acc_cnt++;
                d = d + 8'd1;
                sym_bus.sym_data = d[2:0];
            end
        end
        enable = 1'b0;
        sym_bus.sym_valid = 1'b0;
        chk("accepts_in_12", acc_cnt, 4);
        drain_check("backpressure_drain");

        // Wrap: 8PSK binary 6 (Gray 101), freq 0x40.
        apply_reset();
        freq_word = 8'h40; sps = 8'd8; mode = 2'd2;
        send_sym(3'b101);
        push(8'd192, 1'b1, 1'b0);
        push(8'd0, 1'b0, 1'b0);
        push(8'd64, 1'b0, 1'b0);
        push(8'd128, 1'b0, 1'b0);
        push(8'd192, 1'b0, 1'b0);
        enable = 1'b1;
        repeat (5) tick();
        enable = 1'b0;
        drain_check("wrap_drain");

        // Enable gaps, then async reset with a symbol waiting in the buffer.
        apply_reset();
        freq_word = 8'd1; sps = 8'd8; mode = 2'd0;
        push(8'd0, 1'b0, 1'b1);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        chk("hold_valid_1", 32'(phase_valid), 32'd0);
        chk("hold_phase", 32'(phase), 32'd0);
        tick();
        chk("hold_valid_2", 32'(phase_valid), 32'd0);
        push(8'd1, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        chk("gap_queue", exp_q.size(), 0);
        send_sym(3'd1);
        chk("ready_when_full", 32'(sym_bus.sym_ready), 32'd0);
        enable = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("async_phase", 32'(phase), 32'd0);
        chk("async_phase_valid", 32'(phase_valid), 32'd0);
        chk("async_sym_ready", 32'(sym_bus.sym_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        tick();
        sps = 8'd2;
        send_sym(3'd0);
        push(8'd0, 1'b1, 1'b0);
        push(8'd1, 1'b0, 1'b0);
        enable = 1'b1;
        repeat (2) tick();
        enable = 1'b0;
        drain_check("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
